// File: rtl/midi_note_rx.sv
// MIDI serial receiver (8N1, LSB first) with a Note On/Off parser.
// Tracks the most recently struck note on the selected channel and honours running status.
module midi_note_rx #(
  parameter int unsigned CLKS_PER_BIT = 1600
) (
  input  logic       a_clk,
  input  logic       reset_n,
  input  logic       midi_rx,
  input  logic [3:0] midi_channel,
  input  logic       omni,
  output logic [6:0] note_number,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_valid,
  output logic       framing_error
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;
  typedef enum logic [0:0] {StWaitKey, StWaitVel} parse_state_e;

  rx_state_e    rx_state_q, rx_state_d;
  parse_state_e pst_q, pst_d;

  logic            rx_meta_q, rx_sync_q, rx_prev_q, rx_prev_d;
  logic [1:0]      arm_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_strobe_q, byte_strobe_d;
  logic            framing_error_q, framing_error_d;

  logic [7:0] status_q, status_d;
  logic [6:0] key_q, key_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       note_valid_q, note_valid_d;

  logic note_msg, chan_ok;

  // The synchronizer resets high, so a line held low across reset must not look like a
  // falling edge; rx_prev only tracks the line once the synchronizer holds real samples.
  assign rx_prev_d = rx_sync_q & arm_q[1];

  always_comb begin
    rx_state_d      = rx_state_q;
    cnt_d           = cnt_q + CntW'(1);
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_strobe_d   = 1'b0;
    framing_error_d = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == LastCnt) begin
          rx_state_d      = StIdle;
          byte_strobe_d   = rx_sync_q;
          framing_error_d = !rx_sync_q;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  assign note_msg = (status_q[7:5] == 3'b100);
  assign chan_ok  = omni || (status_q[3:0] == midi_channel);

  always_comb begin
    pst_d        = pst_q;
    status_d     = status_q;
    key_d        = key_q;
    note_d       = note_q;
    vel_d        = vel_q;
    gate_d       = gate_q;
    note_valid_d = 1'b0;
    if (byte_strobe_q) begin
      if (shift_q[7:3] == 5'b11111) begin
        // realtime: transparent to the parser
      end else if (shift_q[7:4] == 4'hF) begin
        status_d = '0;
        pst_d    = StWaitKey;
      end else if (shift_q[7]) begin
        status_d = shift_q;
        pst_d    = StWaitKey;
      end else if (note_msg) begin
        if (pst_q == StWaitKey) begin
          key_d = shift_q[6:0];
          pst_d = StWaitVel;
        end else begin
          pst_d = StWaitKey;
          if (chan_ok) begin
            if (status_q[4] && (shift_q[6:0] != 7'd0)) begin
              note_d       = key_q;
              vel_d        = shift_q[6:0];
              gate_d       = 1'b1;
              note_valid_d = 1'b1;
            end else if (key_q == note_q) begin
              gate_d = 1'b0;
            end
          end
        end
      end
    end
    if (framing_error_q) status_d = '0;
  end

  always_ff @(posedge a_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      rx_prev_q       <= 1'b0;
      arm_q           <= 2'b00;
      rx_state_q      <= StIdle;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      byte_strobe_q   <= 1'b0;
      framing_error_q <= 1'b0;
      pst_q           <= StWaitKey;
      status_q        <= '0;
      key_q           <= '0;
      note_q          <= 7'd48;
      vel_q           <= '0;
      gate_q          <= 1'b0;
      note_valid_q    <= 1'b0;
    end else begin
      rx_meta_q       <= midi_rx;
      rx_sync_q       <= rx_meta_q;
      rx_prev_q       <= rx_prev_d;
      arm_q           <= {arm_q[0], 1'b1};
      rx_state_q      <= rx_state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_strobe_q   <= byte_strobe_d;
      framing_error_q <= framing_error_d;
      pst_q           <= pst_d;
      status_q        <= status_d;
      key_q           <= key_d;
      note_q          <= note_d;
      vel_q           <= vel_d;
      gate_q          <= gate_d;
      note_valid_q    <= note_valid_d;
    end
  end

  assign note_number   = note_q;
  assign velocity      = vel_q;
  assign gate          = gate_q;
  assign note_valid    = note_valid_q;
  assign framing_error = framing_error_q;

endmodule

// File: tb/tb_midi_note_rx.sv
// Bench for midi_note_rx: directed scenarios plus random byte streams against a
// message-level reference model of the MIDI parsing rules.
module tb_midi_note_rx;

  localparam int unsigned Cpb = 16;

  logic       a_clk = 1'b0;
  logic       reset_n;
  logic       midi_rx;
  logic [3:0] midi_channel;
  logic       omni;
  logic [6:0] note_number;
  logic [6:0] velocity;
  logic       gate;
  logic       note_valid;
  logic       framing_error;

  midi_note_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .a_clk         (a_clk),
    .reset_n       (reset_n),
    .midi_rx       (midi_rx),
    .midi_channel  (midi_channel),
    .omni          (omni),
    .note_number   (note_number),
    .velocity      (velocity),
    .gate          (gate),
    .note_valid    (note_valid),
    .framing_error (framing_error)
  );

  always #5 a_clk = ~a_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int nv_seen = 0;
  int fe_seen = 0;

  always @(negedge a_clk) begin
    if (note_valid === 1'b1) nv_seen++;
    if (framing_error === 1'b1) fe_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: status -1 means no running status.
  int m_status, m_key, m_note, m_vel, m_gate, exp_nv, exp_fe;
  bit m_have_key;

  function automatic void model_reset();
    m_status   = -1;
    m_have_key = 1'b0;
    m_key      = 0;
    m_note     = 48;
    m_vel      = 0;
    m_gate     = 0;
  endfunction

  function automatic void model_byte(input int b);
    int kind;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      m_status = -1; m_have_key = 1'b0; return;
    end
    if (b >= 'h80) begin
      m_status = b; m_have_key = 1'b0; return;
    end
    if (m_status < 0) return;
    kind = m_status / 16;
    if (kind != 8 && kind != 9) return;
    if (!m_have_key) begin
      m_key = b; m_have_key = 1'b1; return;
    end
    m_have_key = 1'b0;
    if (!omni && (m_status % 16) != int'(midi_channel)) return;
    if (kind == 9 && b != 0) begin
      m_note = m_key; m_vel = b; m_gate = 1; exp_nv++;
    end else if (m_key == m_note) begin
      m_gate = 0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    midi_rx = 1'b0;
    repeat (Cpb) @(negedge a_clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (Cpb) @(negedge a_clk);
    end
    midi_rx = stop_ok;
    repeat (Cpb) @(negedge a_clk);
    midi_rx = 1'b1;
    repeat (4) @(negedge a_clk);
    if (stop_ok) model_byte(int'(b));
    else begin
      m_status = -1;
      exp_fe++;
    end
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic check_out(input string tag, input int n, input int v, input int g);
    check_eq({tag, ".note"}, 32'(note_number), n);
    check_eq({tag, ".vel"}, 32'(velocity), v);
    check_eq({tag, ".gate"}, 32'(gate), g);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    exp_nv = 0;
    exp_fe = 0;
    model_reset();
    midi_rx      = 1'b1;
    midi_channel = 4'd0;
    omni         = 1'b0;
    reset_n      = 1'b0;
    repeat (5) @(negedge a_clk);
    check_out("reset", 48, 0, 0);
    check_eq("reset.nv", 32'(note_valid), 0);
    check_eq("reset.fe", 32'(framing_error), 0);
    reset_n = 1'b1;
    repeat (200) @(negedge a_clk);
    check_eq("idle.nv_cnt", nv_seen, 0);
    check_eq("idle.fe_cnt", fe_seen, 0);

    send3(8'h90, 8'h3C, 8'h64);
    check_out("on60", 60, 100, 1);
    check_eq("on60.nv_cnt", nv_seen, 1);

    send_byte(8'h40, 1'b1); send_byte(8'h50, 1'b1);
    check_out("rs_on64", 64, 80, 1);
    send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);
    check_out("rs_off60", 64, 80, 1);
    send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
    check_out("rs_off64", 64, 80, 0);

    send_byte(8'h90, 1'b1); send_byte(8'h3E, 1'b1);
    send_byte(8'hF8, 1'b1); send_byte(8'h7F, 1'b1);
    check_out("rt_on62", 62, 127, 1);
    send3(8'h80, 8'h3E, 8'h40);
    check_out("off62", 62, 127, 0);

    send3(8'h91, 8'h30, 8'h40);
    check_out("ch1_rej", 62, 127, 0);
    check_eq("ch1_rej.nv_cnt", nv_seen, exp_nv);
    omni = 1'b1;
    send3(8'h91, 8'h30, 8'h40);
    check_out("omni_on48", 48, 64, 1);
    omni = 1'b0;

    send_byte(8'h55, 1'b0);
    check_eq("ferr.fe_cnt", fe_seen, 1);
    send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    check_out("ferr_ignored", 48, 64, 1);

    midi_rx = 1'b0;
    repeat (4) @(negedge a_clk);
    midi_rx = 1'b1;
    repeat (3 * Cpb) @(negedge a_clk);
    check_out("glitch", 48, 64, 1);
    check_eq("glitch.fe_cnt", fe_seen, exp_fe);
    check_eq("glitch.nv_cnt", nv_seen, exp_nv);

    // Reset during bit 3 of an all-zero byte, with the line still low at release.
    midi_rx = 1'b0;
    repeat (3 * Cpb + Cpb + Cpb / 2) @(negedge a_clk);
    reset_n = 1'b0;
    repeat (2) @(negedge a_clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2 * Cpb) @(negedge a_clk);
    check_out("midrst", 48, 0, 0);
    midi_rx = 1'b1;
    repeat (3 * Cpb) @(negedge a_clk);
    check_eq("midrst.fe_cnt", fe_seen, exp_fe);
    send3(8'h90, 8'h3C, 8'h64);
    check_out("post_rst", 60, 100, 1);

    for (int i = 0; i < 140; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) b = 8'($urandom_range('hF8, 'hFF));
      else if (r < 9) b = 8'($urandom_range('hF0, 'hF7));
      else if (r < 25) b = 8'({3'b100, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 1))});
      else if (r < 28) b = 8'($urandom_range('hA0, 'hEF));
      else if (r < 45) b = 8'(m_note);
      else if (r < 55) b = 8'h00;
      else b = 8'($urandom_range(0, 127));
      send_byte(b, r != 99);
      check_out($sformatf("rnd%0d", i), m_note, m_vel, m_gate);
      if ($urandom_range(0, 15) == 0) omni = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) midi_channel = 4'($urandom_range(0, 1));
    end
    check_eq("final.nv_cnt", nv_seen, exp_nv);
    check_eq("final.fe_cnt", fe_seen, exp_fe);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
